instr_loader: RTL and testbench

Writer side of the instruction ROM/RAM interface read by the fetch stage. Accepts a framed byte stream over a valid/ready handshake from the board UART/switch front-end and assembles little-endian 32-bit instruction words. Writes each word into the instruction memory port and holds the CPU pipeline (cpu_hold) while a program is being loaded. Verifies an XOR checksum at the end of the frame.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/instr_loader_byte_packer.sv | 52 +++++
 rtl/instr_loader.sv | 200 ++++++++++++++++++++
 tb/tb_instr_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction loader:
//   ld_state_e        - loader FSM state encodings
//   DEFAULT_BASE_ADDR - default address of the first word written
//   ld_is_busy()      - true in states that accept stream bytes
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } ld_state_e;

    localparam int unsigned DEFAULT_BASE_ADDR = 0;

    // Busy states are exactly the ones that take bytes from the stream;
    // these are also the states an abort can leave.
    function automatic logic ld_is_busy(input ld_state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_DATA)   || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles four stream bytes into one little-endian 32-bit word (first
// byte lands in bits 7:0).
//   clk, reset   - clock, async active-high reset
//   clear        - drop any partially assembled word, restart at byte 0
//   byte_valid   - byte_in is consumed this cycle
//   byte_in      - payload byte
//   word         - word as it will be once byte_in is shifted in
//   word_ready   - this byte completes a word (word is then complete)
// -----------------------------------------------------------------------------
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    // Bytes enter at the top and shift down, so after four bytes the first
    // one sits in bits 7:0.
    assign word       = {byte_in, word_q[31:8]};
    assign word_ready = byte_valid && !clear && (idx_q == 2'd3);

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (byte_valid) begin
            word_d = word;
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Writer side of the instruction memory. Receives a framed byte stream
//   LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum of the payload
// assembles little-endian words, writes them from BASE_ADDR upward
// (wrapping in the address space) and holds the CPU while loading.
//   clk, reset      - clock, async active-high reset
//   load_start      - pulse, starts a frame from IDLE/DONE/ERROR
//   abort           - abandons a frame in progress (-> ERROR)
//   in_data/valid   - stream byte from the front-end
//   in_ready        - byte accepted this cycle when in_valid is also high
//   mem_addr/wdata  - instruction memory write port
//   mem_wren        - one-cycle write strobe
//   cpu_hold        - holds fetch/PC while loading or after a failed load
//   done / error    - level status of the last frame
//   words_written   - words written in the current/last frame
// -----------------------------------------------------------------------------
module instr_loader
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_written
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    // Largest legal word count is the full memory depth, so 17 bits.
    localparam logic [16:0]       MAX_WORDS = 17'(1 << ADDR_W);

    ld_state_e         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        chk_q, chk_d;
    logic [15:0]       ww_q, ww_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wren_q, wren_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        busy, xfer, start_ok, abort_ok;
    logic [15:0] len_full;
    logic [15:0] ww_inc;
    logic [31:0] pk_word;
    logic        pk_word_ready;

    assign busy     = ld_is_busy(state_q);
    assign start_ok = load_start && !busy;
    assign abort_ok = abort && busy;

    // Abort wins over a simultaneous byte: dropping ready keeps the
    // handshake honest so the source still owns that byte.
    assign in_ready = busy && !abort;
    assign xfer     = in_valid && in_ready;

    assign len_full = {in_data, len_q[7:0]};
    assign ww_inc   = ww_q + 16'd1;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok || abort_ok),
        .byte_valid (xfer && (state_q == ST_DATA)),
        .byte_in    (in_data),
        .word       (pk_word),
        .word_ready (pk_word_ready)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        chk_d   = chk_q;
        ww_d    = ww_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (load_start) begin
                    state_d = ST_LEN_LO;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    ww_d    = '0;
                    chk_d   = '0;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    chk_d = chk_q ^ in_data;
                    if (pk_word_ready) begin
                        // Registered write: strobe appears the cycle after
                        // the 4th byte, address taken before the increment.
                        wren_d  = 1'b1;
                        wdata_d = pk_word;
                        addr_d  = BASE + ww_q[ADDR_W-1:0];
                        ww_d    = ww_inc;
                        if (ww_inc == len_q) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No byte moves while abort is high, so only the state changes.
        if (abort_ok) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            chk_q   <= '0;
            ww_q    <= '0;
            addr_q  <= BASE;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            ww_q    <= ww_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wren      = wren_q;
    assign cpu_hold      = hold_q;
    assign done          = done_q;
    assign error         = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Three loaders: u0 (ADDR_W=16, base 0), u1 (ADDR_W=2, base 0) and
// u2 (ADDR_W=2, base 3). Expected memory writes are queued per instance
// when a frame is issued; a negedge monitor pops and compares every write.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start [3];
    logic        abort      [3];
    logic        in_valid   [3];
    logic [7:0]  in_data    [3];
    logic        in_ready   [3];
    logic        mem_wren   [3];
    logic        cpu_hold   [3];
    logic        done       [3];
    logic        error      [3];
    logic [31:0] mem_wdata  [3];
    logic [15:0] ww         [3];
    logic [15:0] addr0;
    logic [1:0]  addr1, addr2;

    int total = 0;
    int bad   = 0;

    logic [47:0] q0[$];
    logic [47:0] q1[$];
    logic [47:0] q2[$];
    logic [7:0]  pay[$];

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(16), .BASE_ADDR(0)) u0 (
        .clk(clk), .reset(reset), .load_start(load_start[0]), .abort(abort[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mem_addr(addr0), .mem_wdata(mem_wdata[0]), .mem_wren(mem_wren[0]),
        .cpu_hold(cpu_hold[0]), .done(done[0]), .error(error[0]),
        .words_written(ww[0]));

    instr_loader #(.ADDR_W(2), .BASE_ADDR(0)) u1 (
        .clk(clk), .reset(reset), .load_start(load_start[1]), .abort(abort[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mem_addr(addr1), .mem_wdata(mem_wdata[1]), .mem_wren(mem_wren[1]),
        .cpu_hold(cpu_hold[1]), .done(done[1]), .error(error[1]),
        .words_written(ww[1]));

    instr_loader #(.ADDR_W(2), .BASE_ADDR(3)) u2 (
        .clk(clk), .reset(reset), .load_start(load_start[2]), .abort(abort[2]),
        .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .mem_addr(addr2), .mem_wdata(mem_wdata[2]), .mem_wren(mem_wren[2]),
        .cpu_hold(cpu_hold[2]), .done(done[2]), .error(error[2]),
        .words_written(ww[2]));

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(input int k, input logic [15:0] a,
                                     input logic [31:0] d);
        case (k)
            0: q0.push_back({a, d});
            1: q1.push_back({a, d});
            default: q2.push_back({a, d});
        endcase
    endfunction

    // Scoreboard monitor: every write strobe must match the next queued write.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_wren[k] === 1'b1) begin
                logic [47:0] e;
                logic        have;
                logic [15:0] a;
                have = 1'b0;
                e    = '0;
                case (k)
                    0: begin a = addr0;          if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end end
                    1: begin a = {14'd0, addr1}; if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end end
                    default: begin a = {14'd0, addr2}; if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end end
                endcase
                chk($sformatf("u%0d_write_expected", k), {31'd0, have}, 32'd1);
                if (have) begin
                    chk($sformatf("u%0d_wr_addr", k), {16'd0, a}, {16'd0, e[47:32]});
                    chk($sformatf("u%0d_wr_data", k), mem_wdata[k], e[31:0]);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte moved.
    // expw: this byte completes a word, so the write strobe is due next cycle.
    task automatic send_byte(input int k, input logic [7:0] b, input logic expw,
                             input int gap);
        int cnt;
        cnt = 0;
        if (gap > 0) begin
            in_valid[k] = 1'b0;
            repeat ($urandom_range(0, gap)) @(negedge clk);
        end
        in_data[k]  = b;
        in_valid[k] = 1'b1;
        #1;
        while (in_ready[k] !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        chk($sformatf("u%0d_in_ready_wait", k), {31'd0, in_ready[k]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        chk($sformatf("u%0d_wren_latency", k), {31'd0, mem_wren[k]}, {31'd0, expw});
    endtask

    task automatic start(input int k);
        load_start[k] = 1'b1;
        @(negedge clk);
        load_start[k] = 1'b0;
        #1;
        chk($sformatf("u%0d_hold_on_start", k), {31'd0, cpu_hold[k]}, 32'd1);
        chk($sformatf("u%0d_ready_on_start", k), {31'd0, in_ready[k]}, 32'd1);
    endtask

    task automatic frame(input int k, input logic [15:0] n, input logic [7:0] c,
                         input int gap);
        start(k);
        send_byte(k, n[7:0], 1'b0, gap);
        send_byte(k, n[15:8], 1'b0, gap);
        for (int i = 0; i < pay.size(); i++)
            send_byte(k, pay[i], (i % 4) == 3, gap);
        send_byte(k, c, 1'b0, gap);
        #1;
    endtask

    task automatic status(input string nm, input int k, input logic d,
                          input logic e, input logic h, input logic [15:0] w);
        chk({nm, "_done"},  {31'd0, done[k]},     {31'd0, d});
        chk({nm, "_error"}, {31'd0, error[k]},    {31'd0, e});
        chk({nm, "_hold"},  {31'd0, cpu_hold[k]}, {31'd0, h});
        chk({nm, "_words"}, {16'd0, ww[k]},       {16'd0, w});
        chk({nm, "_ready"}, {31'd0, in_ready[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            load_start[k] = 1'b0;
            abort[k]      = 1'b0;
            in_valid[k]   = 1'b0;
            in_data[k]    = 8'h00;
        end
        repeat (3) @(negedge clk);

        // Reset values (async reset still asserted)
        chk("rst_ready", {31'd0, in_ready[0]}, 32'd0);
        chk("rst_wren",  {31'd0, mem_wren[0]}, 32'd0);
        chk("rst_addr0", {16'd0, addr0}, 32'd0);
        chk("rst_addr2", {30'd0, addr2}, 32'd3);
        chk("rst_wdata", mem_wdata[0], 32'd0);
        status("rst", 0, 1'b0, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal load
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00};
        push_exp(0, 16'd0, 32'h0000_0013);
        push_exp(0, 16'd1, 32'h0000_0024);
        frame(0, 16'd2, 8'h37, 0);
        status("nominal", 0, 1'b1, 1'b0, 1'b0, 16'd2);

        // Abort while DONE does nothing
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        #1;
        status("abort_in_done", 0, 1'b1, 1'b0, 1'b0, 16'd2);

        // Bad checksum: words still written, CPU stays held
        push_exp(0, 16'd0, 32'h0000_0013);
        push_exp(0, 16'd1, 32'h0000_0024);
        frame(0, 16'd2, 8'h00, 0);
        status("badchk", 0, 1'b0, 1'b1, 1'b1, 16'd2);

        // Zero length: no writes at all
        pay.delete();
        frame(0, 16'd0, 8'h00, 0);
        status("zero_len", 0, 1'b1, 1'b0, 1'b0, 16'd0);

        // Abort after 5 payload bytes
        start(0);
        send_byte(0, 8'h02, 1'b0, 0);
        send_byte(0, 8'h00, 1'b0, 0);
        push_exp(0, 16'd0, 32'h0000_0013);
        send_byte(0, 8'h13, 1'b0, 0);
        send_byte(0, 8'h00, 1'b0, 0);
        send_byte(0, 8'h00, 1'b0, 0);
        send_byte(0, 8'h00, 1'b1, 0);
        send_byte(0, 8'h24, 1'b0, 0);
        in_data[0]  = 8'h00;
        in_valid[0] = 1'b1;
        abort[0]    = 1'b1;
        #1;
        chk("abort_blocks_ready", {31'd0, in_ready[0]}, 32'd0);
        @(negedge clk);
        abort[0]    = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        status("abort_mid", 0, 1'b0, 1'b1, 1'b1, 16'd1);

        // Reset after 5 payload bytes
        start(0);
        send_byte(0, 8'h02, 1'b0, 0);
        send_byte(0, 8'h00, 1'b0, 0);
        push_exp(0, 16'd0, 32'h0000_0013);
        send_byte(0, 8'h13, 1'b0, 0);
        send_byte(0, 8'h00, 1'b0, 0);
        send_byte(0, 8'h00, 1'b0, 0);
        send_byte(0, 8'h00, 1'b1, 0);
        send_byte(0, 8'h24, 1'b0, 0);
        reset = 1'b1;
        #1;
        chk("rstmid_wren",  {31'd0, mem_wren[0]}, 32'd0);
        chk("rstmid_addr",  {16'd0, addr0}, 32'd0);
        chk("rstmid_wdata", mem_wdata[0], 32'd0);
        status("rstmid", 0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Backpressure: byte held in IDLE is not taken, random gaps later
        in_data[0]  = 8'h02;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_ready", {31'd0, in_ready[0]}, 32'd0);
            @(negedge clk);
        end
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00};
        push_exp(0, 16'd0, 32'h0000_0013);
        push_exp(0, 16'd1, 32'h0000_0024);
        frame(0, 16'd2, 8'h37, 3);
        status("backpressure", 0, 1'b1, 1'b0, 1'b0, 16'd2);

        // Overflow: depth 4, N=5 rejected right after LEN_HI
        start(1);
        send_byte(1, 8'h05, 1'b0, 0);
        send_byte(1, 8'h00, 1'b0, 0);
        #1;
        status("overflow", 1, 1'b0, 1'b1, 1'b1, 16'd0);

        // Boundary: N equal to depth is accepted
        pay = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h04, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00};
        push_exp(1, 16'd0, 32'h0000_0001);
        push_exp(1, 16'd1, 32'h0000_0002);
        push_exp(1, 16'd2, 32'h0000_0004);
        push_exp(1, 16'd3, 32'h0000_0008);
        frame(1, 16'd4, 8'h0F, 0);
        status("full_depth", 1, 1'b1, 1'b0, 1'b0, 16'd4);

        // Address wrap: base 3, two words -> 3 then 0
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00};
        push_exp(2, 16'd3, 32'h0000_0013);
        push_exp(2, 16'd0, 32'h0000_0024);
        frame(2, 16'd2, 8'h37, 0);
        status("wrap", 2, 1'b1, 1'b0, 1'b0, 16'd2);

        repeat (3) @(negedge clk);
        chk("u0_writes_left", q0.size(), 32'd0);
        chk("u1_writes_left", q1.size(), 32'd0);
        chk("u2_writes_left", q2.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
